// File: rtl/disp_sched_pkg.sv
// ----------------------------------------------------------------------------
// disp_sched_pkg
// Shared definitions for the display scheduler slice: display word width,
// FSM state encodings and ms-to-cycles / counter-width helpers.
// No ports (package).
// ----------------------------------------------------------------------------
package disp_sched_pkg;

    localparam int DISP_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_OPEN   = 2'd2;

    function automatic int ms_to_cyc(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

    // Down-counter width for a count of n cycles; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_prio_enc.sv
// ----------------------------------------------------------------------------
// disp_prio_enc
// Combinational fixed-priority encoder, lowest set index wins.
// Ports:
//   req    in   N   request vector
//   onehot out  N   one-hot winner, zero when no request
//   valid  out  1   any request set
// ----------------------------------------------------------------------------
module disp_prio_enc #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic         valid
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = req & (~req + N'(1));
    assign valid  = |req;

endmodule

// File: rtl/disp_sched.sv
// ----------------------------------------------------------------------------
// disp_sched
// Schedules ownership of the 4-digit 7-seg display between NREQ requesters.
// Fixed priority (index 0 highest) with a minimum visible hold time, so a
// value is never flashed too briefly. Feeds disp_data/disp_en to the scanner.
//
// Optional feature macro: DISP_BLINK_EN (owner blink bit toggles disp_en
// every BLINK_CYC cycles). Without it, blink is ignored and disp_en = busy.
//
// Ports:
//   Clk        in   1        clock
//   Rst_n      in   1        async active-low reset
//   req        in   NREQ     level requests
//   req_data   in   16*NREQ  requester k data at [16k+15:16k]
//   blink      in   NREQ     per-requester blink request
//   gnt        out  NREQ     one-hot owner, zero when idle
//   disp_data  out  16       registered display data
//   disp_en    out  1        registered scanner enable
//   busy       out  1        |gnt
//
// state  | meaning
// IDLE   | nobody owns the display
// LOCKED | owner fixed, hold timer running
// OPEN   | hold expired, owner may be replaced or preempted
// ----------------------------------------------------------------------------
module disp_sched
    import disp_sched_pkg::*;
#(
    parameter int              CLK_HZ    = 50_000_000,
    parameter int              NREQ      = 3,
    parameter int              HOLD_MS   = 500,
    parameter logic [DISP_W-1:0] IDLE_DATA = 16'h0000,
    parameter int              BLINK_MS  = 250
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [DISP_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        blink,
    output logic [NREQ-1:0]        gnt,
    output logic [DISP_W-1:0]      disp_data,
    output logic                   disp_en,
    output logic                   busy
);

    localparam int HOLD_CYC  = ms_to_cyc(CLK_HZ, HOLD_MS);
    localparam int BLINK_CYC = ms_to_cyc(CLK_HZ, BLINK_MS);
    localparam int TW        = cnt_w(HOLD_CYC);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC - 1);

    logic [1:0]        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [DISP_W-1:0] data_q, data_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              en_q, en_d;

    logic [NREQ-1:0]   all_oh, hi_oh, req_hi;
    logic              all_valid, hi_valid;
    logic [DISP_W-1:0] data_all, data_hi, data_own;
    logic              owner_req;
    logic              open_eval;
    logic              grant_new;

    // Bits below the owner's index are the higher-priority requesters.
    assign req_hi = req & (gnt_q - NREQ'(1));

    disp_prio_enc #(.N(NREQ)) u_enc_all (
        .req    (req),
        .onehot (all_oh),
        .valid  (all_valid)
    );

    disp_prio_enc #(.N(NREQ)) u_enc_hi (
        .req    (req_hi),
        .onehot (hi_oh),
        .valid  (hi_valid)
    );

    always_comb begin
        data_all = '0;
        data_hi  = '0;
        data_own = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (all_oh[k]) data_all |= req_data[k*DISP_W +: DISP_W];
            if (hi_oh[k])  data_hi  |= req_data[k*DISP_W +: DISP_W];
            if (gnt_q[k])  data_own |= req_data[k*DISP_W +: DISP_W];
        end
    end

    assign owner_req = |(req & gnt_q);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        data_d    = data_q;
        timer_d   = timer_q;
        open_eval = 1'b0;
        grant_new = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (all_valid) begin
                    gnt_d     = all_oh;
                    data_d    = data_all;
                    timer_d   = HOLD_LOAD;
                    state_d   = ST_LOCKED;
                    grant_new = 1'b1;
                end
            end
            ST_LOCKED: begin
                // A dropped owner leaves the last value frozen on screen.
                if (owner_req) data_d = data_own;
                if (timer_q != '0) timer_d = timer_q - TW'(1);
                else               open_eval = 1'b1;
            end
            ST_OPEN: begin
                open_eval = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                data_d  = IDLE_DATA;
                timer_d = '0;
            end
        endcase

        // Expiry and OPEN share one decision so the owner is visible for
        // exactly HOLD_CYC cycles when it is replaced at first opportunity.
        if (open_eval) begin
            if (!owner_req) begin
                if (all_valid) begin
                    gnt_d     = all_oh;
                    data_d    = data_all;
                    timer_d   = HOLD_LOAD;
                    state_d   = ST_LOCKED;
                    grant_new = 1'b1;
                end else begin
                    gnt_d   = '0;
                    data_d  = IDLE_DATA;
                    state_d = ST_IDLE;
                end
            end else if (hi_valid) begin
                gnt_d     = hi_oh;
                data_d    = data_hi;
                timer_d   = HOLD_LOAD;
                state_d   = ST_LOCKED;
                grant_new = 1'b1;
            end else begin
                data_d  = data_own;
                state_d = ST_OPEN;
            end
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BW = cnt_w(BLINK_CYC);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYC - 1);

    logic          phase_q, phase_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_own;

    assign blink_own = |(blink & gnt_q);

    always_comb begin
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        if (grant_new) begin
            phase_d = 1'b1;
            bcnt_d  = BLINK_LOAD;
        end else if (blink_own) begin
            if (bcnt_q == '0) begin
                phase_d = ~phase_q;
                bcnt_d  = BLINK_LOAD;
            end else begin
                bcnt_d  = bcnt_q - BW'(1);
            end
        end else begin
            phase_d = 1'b1;
            bcnt_d  = BLINK_LOAD;
        end
        en_d = (|gnt_d) & phase_d;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            phase_q <= 1'b1;
            bcnt_q  <= BLINK_LOAD;
        end else begin
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^{blink, grant_new, 32'(BLINK_CYC)};
    assign en_d = |gnt_d;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            data_q  <= IDLE_DATA;
            timer_q <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            timer_q <= timer_d;
            en_q    <= en_d;
        end
    end

    assign gnt       = gnt_q;
    assign disp_data = data_q;
    assign disp_en   = en_q;
    assign busy      = |gnt_q;

endmodule

// File: tb/tb_disp_sched.sv
// ----------------------------------------------------------------------------
// tb_disp_sched
// Directed table of per-cycle vectors for disp_sched (1 ms = 1 cycle,
// HOLD 4 cycles, NREQ 3, BLINK 2 cycles), plus hand sequences for async reset
// and blink.
// ----------------------------------------------------------------------------
module tb_disp_sched;

    logic        Clk;
    logic        Rst_n;
    logic [2:0]  req;
    logic [47:0] req_data;
    logic [2:0]  blink;
    logic [2:0]  gnt;
    logic [15:0] disp_data;
    logic        disp_en;
    logic        busy;

    int n_cmp;
    int n_err;

    disp_sched #(
        .CLK_HZ    (1000),
        .NREQ      (3),
        .HOLD_MS   (4),
        .IDLE_DATA (16'h0000),
        .BLINK_MS  (2)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .req       (req),
        .req_data  (req_data),
        .blink     (blink),
        .gnt       (gnt),
        .disp_data (disp_data),
        .disp_en   (disp_en),
        .busy      (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  req;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [2:0]  gnt;
        logic [15:0] data;
        logic        en;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] r, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] c,
                                input logic [2:0] g, input logic [15:0] d,
                                input logic e);
        vec_t v;
        v.req = r; v.d0 = a; v.d1 = b; v.d2 = c;
        v.gnt = g; v.data = d; v.en = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [2:0] g, input logic [15:0] d, input logic e);
        chk({nm, ".gnt"},  16'(gnt), 16'(g));
        chk({nm, ".data"}, disp_data, d);
        chk({nm, ".en"},   16'(disp_en), 16'(e));
        chk({nm, ".busy"}, 16'(busy), 16'(|g));
    endtask

    logic exp_blink[6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        Rst_n = 1'b0;
        req = '0;
        req_data = '0;
        blink = '0;

        // Basic grant and tracking, then release during hold.
        tbl.push_back(mk(3'b100, 16'h0, 16'h0, 16'h1234, 3'b100, 16'h1234, 1));
        tbl.push_back(mk(3'b100, 16'h0, 16'h0, 16'h5678, 3'b100, 16'h5678, 1));
        tbl.push_back(mk(3'b000, 16'h0, 16'h0, 16'h5678, 3'b100, 16'h5678, 1));
        tbl.push_back(mk(3'b000, 16'h0, 16'h0, 16'h0,    3'b100, 16'h5678, 1));
        tbl.push_back(mk(3'b000, 16'h0, 16'h0, 16'h0,    3'b000, 16'h0000, 0));
        tbl.push_back(mk(3'b000, 16'h0, 16'h0, 16'h0,    3'b000, 16'h0000, 0));
        // Higher priority arrives during hold: waits 4 cycles then preempts.
        tbl.push_back(mk(3'b100, 16'h0,    16'h0, 16'h1234, 3'b100, 16'h1234, 1));
        tbl.push_back(mk(3'b101, 16'hEEEE, 16'h0, 16'h1234, 3'b100, 16'h1234, 1));
        tbl.push_back(mk(3'b101, 16'hEEEE, 16'h0, 16'h1234, 3'b100, 16'h1234, 1));
        tbl.push_back(mk(3'b101, 16'hEEEE, 16'h0, 16'h1234, 3'b100, 16'h1234, 1));
        tbl.push_back(mk(3'b101, 16'hEEEE, 16'h0, 16'h1234, 3'b001, 16'hEEEE, 1));
        tbl.push_back(mk(3'b001, 16'hEEEE, 16'h0, 16'h0,    3'b001, 16'hEEEE, 1));
        tbl.push_back(mk(3'b000, 16'h0,    16'h0, 16'h0,    3'b001, 16'hEEEE, 1));
        tbl.push_back(mk(3'b000, 16'h0,    16'h0, 16'h0,    3'b001, 16'hEEEE, 1));
        tbl.push_back(mk(3'b000, 16'h0,    16'h0, 16'h0,    3'b000, 16'h0000, 0));
        // Owner drops 1 cycle after grant: data frozen until hold expires.
        tbl.push_back(mk(3'b100, 16'h0, 16'h0, 16'h1234, 3'b100, 16'h1234, 1));
        tbl.push_back(mk(3'b000, 16'h0, 16'h0, 16'h9999, 3'b100, 16'h1234, 1));
        tbl.push_back(mk(3'b000, 16'h0, 16'h0, 16'h9999, 3'b100, 16'h1234, 1));
        tbl.push_back(mk(3'b000, 16'h0, 16'h0, 16'h9999, 3'b100, 16'h1234, 1));
        tbl.push_back(mk(3'b000, 16'h0, 16'h0, 16'h9999, 3'b000, 16'h0000, 0));
        // Simultaneous requests: index 0 wins; handover to 1 without a gap.
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(3'b011, 16'hAAAA, 16'hBBBB, 16'h0, 3'b001, 16'hAAAA, 1));
        tbl.push_back(mk(3'b010, 16'h0, 16'hBBBB, 16'h0, 3'b010, 16'hBBBB, 1));
        tbl.push_back(mk(3'b010, 16'h0, 16'hBBBB, 16'h0, 3'b010, 16'hBBBB, 1));
        tbl.push_back(mk(3'b000, 16'h0, 16'h0,    16'h0, 3'b010, 16'hBBBB, 1));
        tbl.push_back(mk(3'b000, 16'h0, 16'h0,    16'h0, 3'b010, 16'hBBBB, 1));
        tbl.push_back(mk(3'b000, 16'h0, 16'h0,    16'h0, 3'b000, 16'h0000, 0));
        // Owner drops and reasserts: ownership kept, timer not reloaded.
        tbl.push_back(mk(3'b010, 16'h0,    16'h1111, 16'h0, 3'b010, 16'h1111, 1));
        tbl.push_back(mk(3'b000, 16'h0,    16'h1111, 16'h0, 3'b010, 16'h1111, 1));
        tbl.push_back(mk(3'b010, 16'h0,    16'h2222, 16'h0, 3'b010, 16'h2222, 1));
        tbl.push_back(mk(3'b010, 16'h0,    16'h2222, 16'h0, 3'b010, 16'h2222, 1));
        tbl.push_back(mk(3'b011, 16'h3333, 16'h2222, 16'h0, 3'b001, 16'h3333, 1));
        tbl.push_back(mk(3'b000, 16'h0,    16'h0,    16'h0, 3'b001, 16'h3333, 1));
        tbl.push_back(mk(3'b000, 16'h0,    16'h0,    16'h0, 3'b001, 16'h3333, 1));
        tbl.push_back(mk(3'b000, 16'h0,    16'h0,    16'h0, 3'b001, 16'h3333, 1));
        tbl.push_back(mk(3'b000, 16'h0,    16'h0,    16'h0, 3'b000, 16'h0000, 0));

        #3;
        chk_all("reset", 3'b000, 16'h0000, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk_all("idle", 3'b000, 16'h0000, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            req      = tbl[i].req;
            req_data = {tbl[i].d2, tbl[i].d1, tbl[i].d0};
            @(posedge Clk); #1;
            chk_all($sformatf("row%0d", i), tbl[i].gnt, tbl[i].data, tbl[i].en);
        end

        // Blink on the owner: enable pattern follows the blink phase.
`ifdef DISP_BLINK_EN
        exp_blink = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_blink = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        req      = 3'b100;
        req_data = {16'h4321, 16'h0, 16'h0};
        blink    = 3'b100;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            chk_all($sformatf("blink%0d", i), 3'b100, 16'h4321, exp_blink[i]);
        end
        blink = 3'b000;

        // Async reset in the middle of a grant, checked without any edge.
        Rst_n = 1'b0;
        #2;
        chk_all("async_rst", 3'b000, 16'h0000, 1'b0);
        @(negedge Clk);
        chk_all("rst_held", 3'b000, 16'h0000, 1'b0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk_all("regrant", 3'b100, 16'h4321, 1'b1);

        req = 3'b000;
        repeat (6) @(posedge Clk);
        #1;
        chk_all("final_idle", 3'b000, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
